// File: rtl/codec_pkg.sv
// Shared definitions for the codec register access path.
//   state_e                 arbiter FSM states
//   REQ_INIT / REQ_HOST     requester indices used for grant and round-robin tracking
//   REG_*                   codec register addresses (9-bit)
//   DEFAULT_TIMEOUT_CYCLES  default engine response budget
package codec_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StRespond
  } state_e;

  localparam logic REQ_INIT = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  localparam logic [15:0] DEFAULT_TIMEOUT_CYCLES = 16'd50000;

  localparam logic [8:0] REG_LEFT_LINE_IN  = 9'h000;
  localparam logic [8:0] REG_RIGHT_LINE_IN = 9'h001;
  localparam logic [8:0] REG_LEFT_HP_OUT   = 9'h002;
  localparam logic [8:0] REG_RIGHT_HP_OUT  = 9'h003;
  localparam logic [8:0] REG_ANALOG_PATH   = 9'h004;
  localparam logic [8:0] REG_DIGITAL_PATH  = 9'h005;
  localparam logic [8:0] REG_POWER_DOWN    = 9'h006;
  localparam logic [8:0] REG_DIGITAL_IF    = 9'h007;
  localparam logic [8:0] REG_SAMPLING      = 9'h008;
  localparam logic [8:0] REG_ACTIVE        = 9'h009;
  localparam logic [8:0] REG_RESET         = 9'h00F;

endpackage

// File: rtl/codec_req_slot.sv
// Single-entry pending request slot for one requester.
//   clk, reset          clock, asynchronous active-high reset
//   rd_en, wr_en        request pulses (both high -> write)
//   reg_addr, data_out  request address / write data, sampled with the pulse
//   clear               empties the slot (arbiter has completed the request)
//   busy                slot holds a request
//   is_write, slot_addr, slot_data  captured request
module codec_req_slot (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_en,
  input  logic       wr_en,
  input  logic [8:0] reg_addr,
  input  logic [7:0] data_out,
  input  logic       clear,
  output logic       busy,
  output logic       is_write,
  output logic [8:0] slot_addr,
  output logic [7:0] slot_data
);

  logic       valid_q;
  logic       write_q;
  logic [8:0] addr_q;
  logic [7:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (!valid_q && (rd_en || wr_en)) begin
      // Requests arriving while occupied are dropped, not queued.
      valid_q <= 1'b1;
      write_q <= wr_en;
      addr_q  <= reg_addr;
      data_q  <= data_out;
    end
  end

  assign busy      = valid_q;
  assign is_write  = write_q;
  assign slot_addr = addr_q;
  assign slot_data = data_q;

endmodule

// File: rtl/codec_access_arbiter.sv
// Arbitrates codec register accesses from the init sequencer and the host onto one
// I2C register engine, with round-robin fairness and a per-transaction timeout.
//   clk, reset                        clock, asynchronous active-high reset
//   init_done                         enables host grants
//   {init,host}_rd_en/_wr_en          request pulses
//   {init,host}_reg_addr/_data_out    request address / write data
//   {init,host}_data_in               read data, held until the next read completion
//   {init,host}_done_pulse/_err       completion pulse, timeout flag
//   {init,host}_busy                  request pending or in flight
//   i2c_rd_en/_wr_en, i2c_reg_addr, i2c_data_out   command to the engine
//   i2c_data_in, i2c_done             engine response
module codec_access_arbiter
  import codec_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_done,

  input  logic       init_rd_en,
  input  logic       init_wr_en,
  input  logic [8:0] init_reg_addr,
  input  logic [7:0] init_data_out,
  output logic [7:0] init_data_in,
  output logic       init_done_pulse,
  output logic       init_busy,
  output logic       init_err,

  input  logic       host_rd_en,
  input  logic       host_wr_en,
  input  logic [8:0] host_reg_addr,
  input  logic [7:0] host_data_out,
  output logic [7:0] host_data_in,
  output logic       host_done_pulse,
  output logic       host_busy,
  output logic       host_err,

  output logic       i2c_rd_en,
  output logic       i2c_wr_en,
  output logic [8:0] i2c_reg_addr,
  output logic [7:0] i2c_data_out,
  input  logic [7:0] i2c_data_in,
  input  logic       i2c_done
);

  localparam logic [15:0] TimeoutLast = TIMEOUT_CYCLES - 16'd1;

  state_e      state_q;
  logic        grant_q;
  logic        last_q;
  logic        write_q;
  logic [15:0] cnt_q;

  logic       init_write, host_write;
  logic [8:0] init_addr, host_addr;
  logic [7:0] init_data, host_data;
  logic       init_clear, host_clear;
  logic       init_elig, host_elig, grant_valid, grant_sel;

  codec_req_slot u_init_slot (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (init_rd_en),
    .wr_en     (init_wr_en),
    .reg_addr  (init_reg_addr),
    .data_out  (init_data_out),
    .clear     (init_clear),
    .busy      (init_busy),
    .is_write  (init_write),
    .slot_addr (init_addr),
    .slot_data (init_data)
  );

  codec_req_slot u_host_slot (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (host_rd_en),
    .wr_en     (host_wr_en),
    .reg_addr  (host_reg_addr),
    .data_out  (host_data_out),
    .clear     (host_clear),
    .busy      (host_busy),
    .is_write  (host_write),
    .slot_addr (host_addr),
    .slot_data (host_data)
  );

  always_comb begin
    init_elig   = init_busy;
    host_elig   = host_busy && init_done;
    grant_valid = init_elig || host_elig;
    // On contention the requester not granted last wins.
    grant_sel   = (init_elig && host_elig) ? ~last_q : host_elig;
    init_clear  = (state_q == StRespond) && (grant_q == REQ_INIT);
    host_clear  = (state_q == StRespond) && (grant_q == REQ_HOST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      grant_q         <= REQ_INIT;
      last_q          <= REQ_HOST;
      write_q         <= 1'b0;
      cnt_q           <= '0;
      i2c_rd_en       <= 1'b0;
      i2c_wr_en       <= 1'b0;
      i2c_reg_addr    <= '0;
      i2c_data_out    <= '0;
      init_data_in    <= '0;
      init_done_pulse <= 1'b0;
      init_err        <= 1'b0;
      host_data_in    <= '0;
      host_done_pulse <= 1'b0;
      host_err        <= 1'b0;
    end else begin
      i2c_rd_en       <= 1'b0;
      i2c_wr_en       <= 1'b0;
      init_done_pulse <= 1'b0;
      init_err        <= 1'b0;
      host_done_pulse <= 1'b0;
      host_err        <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            grant_q      <= grant_sel;
            last_q       <= grant_sel;
            write_q      <= grant_sel ? host_write : init_write;
            i2c_reg_addr <= grant_sel ? host_addr : init_addr;
            i2c_data_out <= grant_sel ? host_data : init_data;
            state_q      <= StIssue;
          end
        end

        StIssue: begin
          i2c_rd_en <= ~write_q;
          i2c_wr_en <= write_q;
          cnt_q     <= '0;
          state_q   <= StWaitDone;
        end

        StWaitDone: begin
          // i2c_done wins over an expiring counter in the same cycle.
          if (i2c_done || (cnt_q == TimeoutLast)) begin
            state_q <= StRespond;
            if (grant_q == REQ_HOST) begin
              host_done_pulse <= 1'b1;
              host_err        <= ~i2c_done;
              if (!write_q) host_data_in <= i2c_done ? i2c_data_in : 8'h00;
            end else begin
              init_done_pulse <= 1'b1;
              init_err        <= ~i2c_done;
              if (!write_q) init_data_in <= i2c_done ? i2c_data_in : 8'h00;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        StRespond: begin
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
